// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction fetch sequencer with {pc, instr} FIFO toward decode
// Optional HALT_ON_ZERO_EN: a zero instruction word stops fetch in HALT.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rd,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        halted,
    output logic        busy,
    output logic [31:0] fetch_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   occ_q;
    logic [31:0]   mem_pc_q    [DEPTH];
    logic [31:0]   mem_instr_q [DEPTH];

    logic full;
    logic push;
    logic pop;
    logic zero_halt;
    logic unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef HALT_ON_ZERO_EN
    assign zero_halt = (imem_rd == 32'h0);
    assign halted    = (state_q == S_HALT);
`else
    assign zero_halt = 1'b0;
    assign halted    = 1'b0;
`endif

    assign full      = (occ_q == (AW+1)'(DEPTH));
    assign out_valid = (occ_q != '0);
    assign pop       = out_valid && out_ready && !redirect_valid;
    // A full FIFO may still accept a word when the head leaves in the same cycle.
    assign push      = (state_q == S_FETCH) && !redirect_valid && !zero_halt && (!full || pop);

    assign imem_addr   = pc_q;
    assign fetch_count = cnt_q;
    assign busy        = (state_q == S_FETCH) || out_valid;
    assign out_instr   = out_valid ? mem_instr_q[rd_ptr_q] : 32'h0;
    assign out_pc      = out_valid ? mem_pc_q[rd_ptr_q]    : 32'h0;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        if (redirect_valid) begin
            state_d = S_FETCH;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) state_d = S_FETCH;
                end
                S_FETCH: begin
                    if (zero_halt) begin
                        state_d = S_HALT;
                    end else if (push) begin
                        pc_d  = pc_q + 32'd4;
                        cnt_d = cnt_q + 32'd1;
                    end
                end
                default: begin
                    state_d = state_q;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            occ_q <= occ_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end

    // Storage needs no reset: entries are only visible while occupancy covers them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[wr_ptr_q]    <= pc_q;
            mem_instr_q[wr_ptr_q] <= imem_rd;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - directed self-checking bench for fetch_ctrl
module tb_fetch_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] imem_addr;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halted;
    logic        busy;
    logic [31:0] fetch_count;

    int n_chk  = 0;
    int n_pass = 0;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .start(start),
        .imem_addr(imem_addr), .imem_rd(imem_rd),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halted(halted), .busy(busy), .fetch_count(fetch_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Program image: seven real instructions, then an unprogrammed zero word at 0x1C.
    always_comb begin
        case (imem_addr)
            32'h00:  imem_rd = 32'h0F30_0093;
            32'h04:  imem_rd = 32'h0090_0113;
            32'h08:  imem_rd = 32'h0020_8133;
            32'h0C:  imem_rd = 32'h0031_0193;
            32'h10:  imem_rd = 32'h0041_8213;
            32'h14:  imem_rd = 32'h0052_0293;
            32'h18:  imem_rd = 32'h0062_8313;
            32'h1C:  imem_rd = 32'h0000_0000;
            default: imem_rd = {16'hC0DE, imem_addr[15:0]};
        endcase
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1; start = 1'b0; out_ready = 1'b0;
        redirect_valid = 1'b0; redirect_pc = 32'h0;
        tick; tick;
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL rst_valid got=%0h exp=0", out_valid); else n_pass++;
        n_chk++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got=%0h exp=0", imem_addr); else n_pass++;
        n_chk++; if (fetch_count !== 32'h0) $display("FAIL rst_count got=%0h exp=0", fetch_count); else n_pass++;
        n_chk++; if (out_pc !== 32'h0 || out_instr !== 32'h0) $display("FAIL rst_head got=%0h/%0h exp=0/0", out_pc, out_instr); else n_pass++;
        n_chk++; if (busy !== 1'b0 || halted !== 1'b0) $display("FAIL rst_flags got=%0b%0b exp=00", busy, halted); else n_pass++;
        tick; tick;
        n_chk++; if (fetch_count !== 32'h0 || imem_addr !== 32'h0) $display("FAIL idle_nofetch got=%0h/%0h exp=0/0", fetch_count, imem_addr); else n_pass++;
    endtask

    task automatic test_stream;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0F30_0093; exp_w[1] = 32'h0090_0113; exp_w[2] = 32'h0020_8133;
        do_reset;
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL stream_gap got=%0h exp=0", out_valid); else n_pass++;
        n_chk++; if (busy !== 1'b1) $display("FAIL stream_busy got=%0h exp=1", busy); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick;
            n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'(i * 4)) $display("FAIL stream_pc%0d got=%0h exp=%0h", i, out_pc, i * 4); else n_pass++;
            n_chk++; if (out_instr !== exp_w[i]) $display("FAIL stream_instr%0d got=%0h exp=%0h", i, out_instr, exp_w[i]); else n_pass++;
            n_chk++; if (fetch_count !== 32'(i + 1)) $display("FAIL stream_count%0d got=%0d exp=%0d", i, fetch_count, i + 1); else n_pass++;
        end
    endtask

    task automatic test_backpressure;
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h0F30_0093; exp_w[1] = 32'h0090_0113; exp_w[2] = 32'h0020_8133;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        n_chk++; if (imem_addr !== 32'h08) $display("FAIL bp_addr got=%0h exp=8", imem_addr); else n_pass++;
        n_chk++; if (fetch_count !== 32'd2) $display("FAIL bp_count got=%0d exp=2", fetch_count); else n_pass++;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'(k * 4) || out_instr !== exp_w[k])
                $display("FAIL bp_head%0d got=%0h/%0h exp=%0h/%0h", k, out_pc, out_instr, k * 4, exp_w[k]); else n_pass++;
            tick;
        end
        n_chk++; if (fetch_count !== 32'd5) $display("FAIL bp_count_end got=%0d exp=5", fetch_count); else n_pass++;
    endtask

    task automatic test_redirect;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        out_ready = 1'b1;
        tick;
        out_ready = 1'b0;
        n_chk++; if (out_pc !== 32'h04 || fetch_count !== 32'd3) $display("FAIL redir_setup got=%0h/%0d exp=4/3", out_pc, fetch_count); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h13;
        tick;
        redirect_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0) $display("FAIL redir_flush got=%0h exp=0", out_valid); else n_pass++;
        n_chk++; if (fetch_count !== 32'd3) $display("FAIL redir_count got=%0d exp=3", fetch_count); else n_pass++;
        n_chk++; if (imem_addr !== 32'h10) $display("FAIL redir_addr got=%0h exp=10", imem_addr); else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h0041_8213)
            $display("FAIL redir_target got=%0h/%0h exp=10/418213", out_pc, out_instr); else n_pass++;
    endtask

    task automatic test_redirect_vs_pop;
        out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h04;
        n_chk++; if (out_valid !== 1'b1) $display("FAIL rvp_pre got=%0h exp=1", out_valid); else n_pass++;
        tick;
        redirect_valid = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || imem_addr !== 32'h04) $display("FAIL rvp_flush got=%0h/%0h exp=0/4", out_valid, imem_addr); else n_pass++;
        n_chk++; if (fetch_count !== 32'd4) $display("FAIL rvp_count got=%0d exp=4", fetch_count); else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h04 || out_instr !== 32'h0090_0113)
            $display("FAIL rvp_target got=%0h/%0h exp=4/900113", out_pc, out_instr); else n_pass++;
    endtask

`ifdef HALT_ON_ZERO_EN
    task automatic test_halt_on_zero;
        int n_del;
        logic [31:0] exp_pc;
        n_del = 0; exp_pc = 32'h0;
        do_reset;
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 30 && !(halted && !busy); c++) begin
            if (out_valid) begin
                n_chk++; if (out_pc !== exp_pc) $display("FAIL halt_pc got=%0h exp=%0h", out_pc, exp_pc); else n_pass++;
                exp_pc = exp_pc + 32'd4;
                n_del++;
            end
            tick;
        end
        n_chk++; if (n_del != 7) $display("FAIL halt_delivered got=%0d exp=7", n_del); else n_pass++;
        n_chk++; if (halted !== 1'b1 || busy !== 1'b0) $display("FAIL halt_flags got=%0b%0b exp=10", halted, busy); else n_pass++;
        n_chk++; if (imem_addr !== 32'h1C || fetch_count !== 32'd7) $display("FAIL halt_state got=%0h/%0d exp=1c/7", imem_addr, fetch_count); else n_pass++;
        redirect_valid = 1'b1; redirect_pc = 32'h0;
        tick;
        redirect_valid = 1'b0;
        n_chk++; if (halted !== 1'b0 || imem_addr !== 32'h0) $display("FAIL halt_exit got=%0b/%0h exp=0/0", halted, imem_addr); else n_pass++;
        tick;
        n_chk++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL halt_refetch got=%0h/%0h exp=1/0", out_valid, out_pc); else n_pass++;
    endtask
`else
    task automatic test_zero_word;
        logic found;
        found = 1'b0;
        do_reset;
        out_ready = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        for (int c = 0; c < 30 && !found; c++) begin
            tick;
            if (out_valid && out_pc == 32'h1C) found = 1'b1;
        end
        n_chk++; if (found !== 1'b1) $display("FAIL zero_reached got=%0b exp=1", found); else n_pass++;
        n_chk++; if (out_instr !== 32'h0 || halted !== 1'b0) $display("FAIL zero_word got=%0h/%0b exp=0/0", out_instr, halted); else n_pass++;
        n_chk++; if (fetch_count !== 32'd8) $display("FAIL zero_count got=%0d exp=8", fetch_count); else n_pass++;
    endtask
`endif

    task automatic test_reset_midflight;
        do_reset;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick; tick;
        n_chk++; if (out_valid !== 1'b1 || fetch_count !== 32'd2) $display("FAIL mrst_pre got=%0h/%0d exp=1/2", out_valid, fetch_count); else n_pass++;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n_chk++; if (out_valid !== 1'b0 || imem_addr !== 32'h0) $display("FAIL mrst_clear got=%0h/%0h exp=0/0", out_valid, imem_addr); else n_pass++;
        n_chk++; if (fetch_count !== 32'h0 || busy !== 1'b0) $display("FAIL mrst_idle got=%0d/%0b exp=0/0", fetch_count, busy); else n_pass++;
        tick; tick; tick;
        n_chk++; if (fetch_count !== 32'h0 || out_valid !== 1'b0 || imem_addr !== 32'h0)
            $display("FAIL mrst_nofetch got=%0d/%0h/%0h exp=0/0/0", fetch_count, out_valid, imem_addr); else n_pass++;
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect;
        test_redirect_vs_pop;
`ifdef HALT_ON_ZERO_EN
        test_halt_on_zero;
`else
        test_zero_word;
`endif
        test_reset_midflight;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle instruction memory (combinational ROM: 32-bit pc in, 32-bit word out, same cycle). Owns the program counter and drives the memory address. Buffers fetched words in a small FIFO and hands them to decode over a valid/ready handshake. Handles start, branch/jump redirect with flush, and halt.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; fetch starts here.
DEPTH, 2, FIFO entries of {pc, instr}; power of two, >= 2.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  leave IDLE and begin fetching
imem_addr  output  32  address to instruction memory (= pc_q)
imem_rd  input  32  word returned by instruction memory, same cycle
out_valid  output  1  FIFO head holds a valid instruction
out_ready  input  1  decode accepts head this cycle
out_instr  output  32  head instruction word
out_pc  output  32  address of head instruction
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  new fetch address; bits [1:0] forced to 0
halted  output  1  fetch stopped in HALT
busy  output  1  state==FETCH or FIFO non-empty
fetch_count  output  32  count of words pushed into the FIFO

Behaviour:
- Reset (synchronous, highest priority, any state, mid-transfer included): state=IDLE, pc_q=RESET_PC, FIFO empty, fetch_count=0. All outputs 0 except imem_addr=RESET_PC.
- States: IDLE, FETCH, HALT.
- IDLE -> FETCH when start=1. start is ignored outside IDLE. No fetch occurs in IDLE.
- Push: in FETCH, a push occurs when no redirect is present and (FIFO not full, or full with a pop this cycle).
  - Push writes {pc_q, imem_rd}, sets pc_q <= pc_q+4 (wraps mod 2^32) and fetch_count <= fetch_count+1 (wraps).
- Pop: occurs when out_valid && out_ready && !redirect_valid.
- A pop and a push in the same cycle are both performed. Occupancy is unchanged.
- out_valid = FIFO non-empty. out_instr/out_pc show the head, and are 0 when the FIFO is empty.
- Latency: a word fetched at edge N is visible on the outputs in the cycle after N. With start sampled at edge S, the first out_valid appears after edge S+1.
- Full FIFO with no pop: pc_q and imem_addr hold. No word is lost or duplicated.
- Redirect (priority below reset, above everything else):
  - FIFO is flushed. The same-cycle head is discarded and not counted as consumed.
  - pc_q <= {redirect_pc[31:2], 2'b00}. No push that cycle.
  - From IDLE or HALT, a redirect also moves the state to FETCH.
  - fetch_count is not decremented for flushed entries.
- halted = (state==HALT). busy = (state==FETCH) || out_valid.

Optional Feature:
HALT_ON_ZERO_EN
- Defined:
  - In FETCH, if imem_rd==32'h0 (unprogrammed location), no push occurs and the state goes to HALT.
  - pc_q holds the address of the zero word, and fetch_count is not incremented.
  - The FIFO continues to drain normally.
  - HALT is exited only by redirect or reset.
- Not defined:
  - Zero words are pushed like any other word. HALT is unreachable and halted is tied to 0.

Test Plan:
- Reset, start=1 for one cycle, out_ready=1 -> from the 2nd cycle after start, one instruction per cycle: (pc 0x00, 0x0F300093), (0x04, 0x00900113), (0x08, 0x00208133). fetch_count increments by 1 per cycle.
- Backpressure: out_ready=0 after start -> FIFO holds pc 0x00 and 0x04; imem_addr holds 0x08; fetch_count=2. Set out_ready=1 -> output continues 0x00, 0x04, 0x08 with no gap, loss or duplicate.
- Redirect with FIFO holding 0x04/0x08, redirect_pc=0x13 -> next out_valid shows out_pc=0x10. Flushed entries never appear. fetch_count is unchanged on the redirect cycle.
- Simultaneous redirect and a valid handshake (out_ready=1) -> head not popped; flush wins; next head is the redirect target.
- HALT_ON_ZERO_EN defined, out_ready=1 -> seven instructions 0x00..0x18 delivered, then halted=1, imem_addr=0x1C, fetch_count=7, busy=0 once drained. Redirect to 0x00 -> halted=0 and refetch from 0x00.
- rst asserted with FIFO full in FETCH -> next cycle: out_valid=0, imem_addr=RESET_PC, fetch_count=0, IDLE. No fetch until start.
